// File: rtl/ps2_keycode_rx_if.sv
// PS/2 keyboard front end: output bundle of keycode and raw-byte results.
// master drives it (receiver), slave consumes it (game FSM).
interface ps2_keycode_rx_if;
  logic [7:0] keycode;
  logic       key_event;
  logic [7:0] raw_byte;
  logic       raw_valid;
  logic       frame_err;

  modport master (
    output keycode,
    output key_event,
    output raw_byte,
    output raw_valid,
    output frame_err
  );

  modport slave (
    input keycode,
    input key_event,
    input raw_byte,
    input raw_valid,
    input frame_err
  );
endinterface

// File: rtl/ps2_keycode_rx.sv
// PS/2 set-2 receiver, make/break tracking and HID translation.
// Optional macro PS2_ARROW_EN: extended arrow keys alias W/A/S/D.
module ps2_keycode_rx #(
  parameter int FILTER_LEN  = 8,
  parameter int TIMEOUT_CYC = 50000
) (
  input  logic Clk,
  input  logic Reset_n,
  input  logic PS2_CLK,
  input  logic PS2_DAT,
  ps2_keycode_rx_if.master kb
);

  localparam int FW = $clog2(FILTER_LEN + 1);
  localparam int TW = $clog2(TIMEOUT_CYC + 1);
  localparam logic [FW-1:0] FLIM = FW'(FILTER_LEN - 1);
  localparam logic [TW-1:0] TLIM = TW'(TIMEOUT_CYC - 1);

  typedef enum logic [1:0] {
    IDLE,
    DATA,
    PARITY,
    STOP
  } state_t;

  logic          clk_s1_q, clk_s2_q;
  logic          dat_s1_q, dat_s2_q;
  logic          filt_q, filt_d;
  logic [FW-1:0] fcnt_q, fcnt_d;
  logic          fall;

  state_t        state_q, state_d;
  logic [2:0]    bitcnt_q, bitcnt_d;
  logic [7:0]    shift_q, shift_d;
  logic          par_q, par_d;
  logic [TW-1:0] tmo_q, tmo_d;
  logic [7:0]    byte_q, byte_d;
  logic          rv_q, rv_d;
  logic          err_q, err_d;

  logic          brk_q, brk_d;
  logic          ext_q, ext_d;
  logic [7:0]    kc_q, kc_d;
  logic          ev_q, ev_d;
  logic [7:0]    hid;

  function automatic logic [7:0] hid_map(
    input logic [7:0] b,
    input logic       e
  );
    hid_map = 8'h00;
    if (!e) begin
      case (b)
        8'h1D:   hid_map = 8'h1A;
        8'h1C:   hid_map = 8'h04;
        8'h1B:   hid_map = 8'h16;
        8'h23:   hid_map = 8'h07;
        8'h5A:   hid_map = 8'h28;
        8'h76:   hid_map = 8'h29;
        default: hid_map = 8'h00;
      endcase
    end else begin
`ifdef PS2_ARROW_EN
      case (b)
        8'h75:   hid_map = 8'h1A;
        8'h72:   hid_map = 8'h16;
        8'h6B:   hid_map = 8'h04;
        8'h74:   hid_map = 8'h07;
        default: hid_map = 8'h00;
      endcase
`else
      hid_map = 8'h00;
`endif
    end
  endfunction

  // Two-flop synchronizers; idle bus level is high.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      clk_s1_q <= 1'b1;
      clk_s2_q <= 1'b1;
      dat_s1_q <= 1'b1;
      dat_s2_q <= 1'b1;
    end else begin
      clk_s1_q <= PS2_CLK;
      clk_s2_q <= clk_s1_q;
      dat_s1_q <= PS2_DAT;
      dat_s2_q <= dat_s1_q;
    end
  end

  // Glitch filter: toggle only after FILTER_LEN differing samples in a row.
  always_comb begin
    filt_d = filt_q;
    fcnt_d = '0;
    fall   = 1'b0;
    if (clk_s2_q != filt_q) begin
      if (fcnt_q == FLIM) begin
        filt_d = clk_s2_q;
        fall   = filt_q;
      end else begin
        fcnt_d = fcnt_q + 1'b1;
      end
    end
  end

  // Filter state register.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      filt_q <= 1'b1;
      fcnt_q <= '0;
    end else begin
      filt_q <= filt_d;
      fcnt_q <= fcnt_d;
    end
  end

  // Frame FSM next state: bits advance on filtered falls, watchdog aborts.
  always_comb begin
    state_d  = state_q;
    bitcnt_d = bitcnt_q;
    shift_d  = shift_q;
    par_d    = par_q;
    tmo_d    = '0;
    byte_d   = byte_q;
    rv_d     = 1'b0;
    err_d    = 1'b0;
    if (fall) begin
      unique case (state_q)
        IDLE: begin
          if (!dat_s2_q) begin
            state_d  = DATA;
            bitcnt_d = 3'd0;
          end else begin
            err_d = 1'b1;
          end
        end
        DATA: begin
          shift_d  = {dat_s2_q, shift_q[7:1]};
          bitcnt_d = bitcnt_q + 3'd1;
          if (bitcnt_q == 3'd7) state_d = PARITY;
        end
        PARITY: begin
          par_d   = dat_s2_q;
          state_d = STOP;
        end
        STOP: begin
          state_d = IDLE;
          if (dat_s2_q && (^{shift_q, par_q})) begin
            rv_d   = 1'b1;
            byte_d = shift_q;
          end else begin
            err_d = 1'b1;
          end
        end
        default: state_d = IDLE;
      endcase
    end else if (state_q != IDLE) begin
      if (tmo_q == TLIM) begin
        state_d = IDLE;
        err_d   = 1'b1;
      end else begin
        tmo_d = tmo_q + 1'b1;
      end
    end
  end

  // Frame FSM registers and result pulses.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q  <= IDLE;
      bitcnt_q <= 3'd0;
      shift_q  <= 8'h00;
      par_q    <= 1'b0;
      tmo_q    <= '0;
      byte_q   <= 8'h00;
      rv_q     <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      bitcnt_q <= bitcnt_d;
      shift_q  <= shift_d;
      par_q    <= par_d;
      tmo_q    <= tmo_d;
      byte_q   <= byte_d;
      rv_q     <= rv_d;
      err_q    <= err_d;
    end
  end

  assign hid = hid_map(byte_q, ext_q);

  // Prefix tracking and held-key decode, one cycle after raw_valid.
  always_comb begin
    brk_d = brk_q;
    ext_d = ext_q;
    kc_d  = kc_q;
    ev_d  = 1'b0;
    if (err_q) begin
      brk_d = 1'b0;
      ext_d = 1'b0;
    end else if (rv_q) begin
      unique case (1'b1)
        (byte_q == 8'hF0): brk_d = 1'b1;
        (byte_q == 8'hE0): ext_d = 1'b1;
        default: begin
          brk_d = 1'b0;
          ext_d = 1'b0;
          if (hid != 8'h00) begin
            if (!brk_q && hid != kc_q) begin
              kc_d = hid;
              ev_d = 1'b1;
            end else if (brk_q && hid == kc_q) begin
              kc_d = 8'h00;
              ev_d = 1'b1;
            end
          end
        end
      endcase
    end
  end

  // Decode registers.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      brk_q <= 1'b0;
      ext_q <= 1'b0;
      kc_q  <= 8'h00;
      ev_q  <= 1'b0;
    end else begin
      brk_q <= brk_d;
      ext_q <= ext_d;
      kc_q  <= kc_d;
      ev_q  <= ev_d;
    end
  end

  assign kb.keycode   = kc_q;
  assign kb.key_event = ev_q;
  assign kb.raw_byte  = byte_q;
  assign kb.raw_valid = rv_q;
  assign kb.frame_err = err_q;

endmodule

// File: tb/tb_ps2_keycode_rx.sv
// Directed bench for ps2_keycode_rx: frame table plus timeout
// and mid-frame reset sequences.
module tb_ps2_keycode_rx;

  localparam int TMO  = 2000;
  localparam int HALF = 20;

`ifdef PS2_ARROW_EN
  localparam logic [7:0] ARROW_KC = 8'h1A;
  localparam int         ARROW_EV = 1;
`else
  localparam logic [7:0] ARROW_KC = 8'h00;
  localparam int         ARROW_EV = 0;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic ps2_clk = 1'b1;
  logic ps2_dat = 1'b1;

  ps2_keycode_rx_if kb_if ();

  ps2_keycode_rx #(
    .FILTER_LEN (8),
    .TIMEOUT_CYC(TMO)
  ) dut (
    .Clk    (clk),
    .Reset_n(rst_n),
    .PS2_CLK(ps2_clk),
    .PS2_DAT(ps2_dat),
    .kb     (kb_if)
  );

  always #10 clk = ~clk;

  int cmp_n = 0;
  int bad_n = 0;

  int cyc = 0;
  int rv_n = 0;
  int er_n = 0;
  int ev_n = 0;
  int both_n = 0;
  int rv_cyc = 0;
  int ev_cyc = 0;

  always @(negedge clk) begin
    cyc = cyc + 1;
    if (kb_if.raw_valid) begin
      rv_n = rv_n + 1;
      rv_cyc = cyc;
    end
    if (kb_if.frame_err) er_n = er_n + 1;
    if (kb_if.key_event) begin
      ev_n = ev_n + 1;
      ev_cyc = cyc;
    end
    if (kb_if.raw_valid && kb_if.frame_err) both_n = both_n + 1;
  end

  task automatic chk(input string nm, input int act, input int exp);
    cmp_n = cmp_n + 1;
    if (act != exp) begin
      bad_n = bad_n + 1;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  task automatic wait_clk(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send_bits(input logic [10:0] f, input int n);
    for (int i = 0; i < n; i++) begin
      ps2_dat = f[i];
      wait_clk(HALF);
      ps2_clk = 1'b0;
      wait_clk(HALF);
      ps2_clk = 1'b1;
    end
    ps2_dat = 1'b1;
  endtask

  function automatic logic [10:0] mk(input logic [7:0] d, input logic bad);
    logic p;
    p  = ~(^d);
    mk = {1'b1, p ^ bad, d, 1'b0};
  endfunction

  typedef struct {
    logic [7:0] b;
    logic       bad;
    int         rv;
    int         er;
    logic [7:0] kc;
    int         ev;
  } vec_t;

  vec_t tv[18];

  int rv0, er0, ev0;
  logic [7:0] last_raw;

  initial begin
    tv[0]  = '{8'h1D, 1'b0, 1, 0, 8'h1A, 1};
    tv[1]  = '{8'h1D, 1'b0, 1, 0, 8'h1A, 0};
    tv[2]  = '{8'h1D, 1'b0, 1, 0, 8'h1A, 0};
    tv[3]  = '{8'hF0, 1'b0, 1, 0, 8'h1A, 0};
    tv[4]  = '{8'h1D, 1'b0, 1, 0, 8'h00, 1};
    tv[5]  = '{8'h1C, 1'b0, 1, 0, 8'h04, 1};
    tv[6]  = '{8'h1B, 1'b0, 1, 0, 8'h16, 1};
    tv[7]  = '{8'hF0, 1'b0, 1, 0, 8'h16, 0};
    tv[8]  = '{8'h1C, 1'b0, 1, 0, 8'h16, 0};
    tv[9]  = '{8'hF0, 1'b0, 1, 0, 8'h16, 0};
    tv[10] = '{8'h1B, 1'b0, 1, 0, 8'h00, 1};
    tv[11] = '{8'h5A, 1'b1, 0, 1, 8'h00, 0};
    tv[12] = '{8'h76, 1'b0, 1, 0, 8'h29, 1};
    tv[13] = '{8'hF0, 1'b0, 1, 0, 8'h29, 0};
    tv[14] = '{8'hF0, 1'b0, 1, 0, 8'h29, 0};
    tv[15] = '{8'h76, 1'b0, 1, 0, 8'h00, 1};
    tv[16] = '{8'hE0, 1'b0, 1, 0, 8'h00, 0};
    tv[17] = '{8'h75, 1'b0, 1, 0, ARROW_KC, ARROW_EV};

    wait_clk(5);
    chk("reset_keycode", int'(kb_if.keycode), 0);
    chk("reset_raw_byte", int'(kb_if.raw_byte), 0);
    chk("reset_flags",
        int'({kb_if.key_event, kb_if.raw_valid, kb_if.frame_err}), 0);
    rst_n = 1'b1;
    wait_clk(5);
    chk("idle_no_pulses", rv_n + er_n + ev_n, 0);

    last_raw = 8'h00;
    for (int i = 0; i < 18; i++) begin
      rv0 = rv_n;
      er0 = er_n;
      ev0 = ev_n;
      send_bits(mk(tv[i].b, tv[i].bad), 11);
      wait_clk(30);
      if (!tv[i].bad) last_raw = tv[i].b;
      chk($sformatf("v%0d_raw_valid", i), rv_n - rv0, tv[i].rv);
      chk($sformatf("v%0d_frame_err", i), er_n - er0, tv[i].er);
      chk($sformatf("v%0d_keycode", i), int'(kb_if.keycode), int'(tv[i].kc));
      chk($sformatf("v%0d_key_event", i), ev_n - ev0, tv[i].ev);
      chk($sformatf("v%0d_raw_byte", i), int'(kb_if.raw_byte), int'(last_raw));
      if (i == 0) chk("v0_event_lag", ev_cyc - rv_cyc, 1);
    end

    rv0 = rv_n;
    er0 = er_n;
    ev0 = ev_n;
    send_bits(mk(8'h5A, 1'b0), 5);
    wait_clk(TMO / 2);
    chk("tmo_not_early", er_n - er0, 0);
    wait_clk(TMO / 2 + 40);
    chk("tmo_frame_err", er_n - er0, 1);
    chk("tmo_raw_valid", rv_n - rv0, 0);
    chk("tmo_keycode", int'(kb_if.keycode), int'(ARROW_KC));

    ev0 = ev_n;
    send_bits(mk(8'h5A, 1'b0), 11);
    wait_clk(30);
    chk("after_tmo_keycode", int'(kb_if.keycode), 8'h28);
    chk("after_tmo_event", ev_n - ev0, 1);
    chk("after_tmo_raw", int'(kb_if.raw_byte), 8'h5A);

    send_bits(mk(8'h1C, 1'b0), 5);
    wait_clk(3);
    rst_n = 1'b0;
    #3;
    chk("rst_mid_keycode", int'(kb_if.keycode), 0);
    chk("rst_mid_raw_byte", int'(kb_if.raw_byte), 0);
    chk("rst_mid_flags",
        int'({kb_if.key_event, kb_if.raw_valid, kb_if.frame_err}), 0);
    wait_clk(3);
    rst_n = 1'b1;
    wait_clk(5);

    rv0 = rv_n;
    er0 = er_n;
    ev0 = ev_n;
    send_bits(mk(8'h1D, 1'b0), 11);
    wait_clk(30);
    chk("post_rst_raw_valid", rv_n - rv0, 1);
    chk("post_rst_frame_err", er_n - er0, 0);
    chk("post_rst_keycode", int'(kb_if.keycode), 8'h1A);
    chk("post_rst_event", ev_n - ev0, 1);

    chk("rv_err_overlap", both_n, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_n, bad_n);
    $finish;
  end

endmodule
